// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one synchronous memory port between instruction fetch and data access
// Alternating-priority grant, WAIT_STATES extra enable cycles, one-cycle done pulse per access.
module mem_arbiter #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  f_req,
    input  logic [ADDR_WIDTH-1:0] f_addr,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  f_done,
    output logic                  d_done,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  owner,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    logic [1:0] state;
    logic [3:0] wait_cnt;
    logic       grant_any;
    logic       grant_data;

    // Under contention the requester that did not win last time is served.
    always_comb begin
        grant_any  = f_req | d_req;
        grant_data = d_req & (~f_req | ~owner);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            wait_cnt  <= 4'd0;
            f_done    <= 1'b0;
            d_done    <= 1'b0;
            rdata     <= '0;
            busy      <= 1'b0;
            owner     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        state    <= ST_ACCESS;
                        owner    <= grant_data;
                        busy     <= 1'b1;
                        mem_en   <= 1'b1;
                        wait_cnt <= WAIT_LOAD;
                        if (grant_data) begin
                            mem_addr  <= d_addr;
                            mem_we    <= d_we;
                            mem_wdata <= d_wdata;
                        end else begin
                            mem_addr  <= f_addr;
                            mem_we    <= 1'b0;
                            mem_wdata <= '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        // Last access cycle: memory read data is valid now.
                        state  <= ST_DONE;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        if (!mem_we) begin
                            rdata <= mem_rdata;
                        end
                        if (owner) begin
                            d_done <= 1'b1;
                        end else begin
                            f_done <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    f_done <= 1'b0;
                    d_done <= 1'b0;
                    busy   <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    f_done <= 1'b0;
                    d_done <= 1'b0;
                    busy   <= 1'b0;
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized and directed checks of mem_arbiter against a cycle-offset model
module tb_mem_arbiter;

    localparam int WS = 1;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        f_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [15:0] f_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic        f_done, d_done, busy, owner, mem_en, mem_we;
    logic [15:0] rdata, mem_addr, mem_wdata;

    logic        f_req0 = 1'b0, d_req0 = 1'b0, d_we0 = 1'b0;
    logic [15:0] f_addr0 = '0, d_addr0 = '0, d_wdata0 = '0, mem_rdata0 = '0;
    logic        f_done0, d_done0, busy0, owner0, mem_en0, mem_we0;
    logic [15:0] rdata0, mem_addr0, mem_wdata0;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .f_done(f_done), .d_done(d_done), .rdata(rdata), .busy(busy), .owner(owner),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset),
        .f_req(f_req0), .f_addr(f_addr0),
        .d_req(d_req0), .d_we(d_we0), .d_addr(d_addr0), .d_wdata(d_wdata0),
        .f_done(f_done0), .d_done(d_done0), .rdata(rdata0), .busy(busy0), .owner(owner0),
        .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
        .mem_rdata(mem_rdata0)
    );

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an access granted at edge g owns cycles g+1 .. g+WS+2 (WS+1 enable cycles, then done).
    int          edge_n = 0;
    int          g_edge = 0;
    bit          have_grant = 1'b0;
    bit          m_owner = 1'b0;
    bit          m_we = 1'b0;
    logic [15:0] m_addr = '0, m_wdata = '0, m_rdata = '0;

    always @(posedge clk or posedge reset) begin
        int  k_prev;
        bit  take_data;
        if (reset) begin
            edge_n = 0; have_grant = 1'b0; m_owner = 1'b0; m_we = 1'b0;
            m_addr = '0; m_wdata = '0; m_rdata = '0;
        end else begin
            edge_n++;
            k_prev = edge_n - g_edge;
            if (have_grant && k_prev == WS + 1 && !m_we) m_rdata = mem_rdata;
            if ((!have_grant || k_prev >= WS + 3) && (f_req || d_req)) begin
                if (f_req && d_req) take_data = (m_owner == 1'b0);
                else                take_data = d_req;
                m_owner    = take_data;
                m_addr     = take_data ? d_addr : f_addr;
                m_we       = take_data ? d_we : 1'b0;
                m_wdata    = d_wdata;
                g_edge     = edge_n;
                have_grant = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        int k;
        bit e_en, e_busy, e_done;
        if (chk_on) begin
            k      = have_grant ? (edge_n - g_edge + 1) : 0;
            e_en   = (k >= 1 && k <= WS + 1);
            e_busy = (k >= 1 && k <= WS + 2);
            e_done = (k == WS + 2);
            cmp("m_mem_en", mem_en, e_en);
            cmp("m_mem_we", mem_we, e_en && m_we);
            cmp("m_busy", busy, e_busy);
            cmp("m_f_done", f_done, e_done && !m_owner);
            cmp("m_d_done", d_done, e_done && m_owner);
            cmp("m_owner", owner, m_owner);
            cmp("m_rdata", rdata, m_rdata);
            if (e_en) cmp("m_mem_addr", mem_addr, m_addr);
            if (e_en && m_we) cmp("m_mem_wdata", mem_wdata, m_wdata);
        end
    end

    task automatic next();
        @(negedge clk);
    endtask

    initial begin
        repeat (3) next();
        chk_on = 1'b1;
        cmp("rst_mem_en", mem_en, 0);
        cmp("rst_busy", busy, 0);
        cmp("rst_owner", owner, 0);
        cmp("rst_rdata", rdata, 0);
        cmp("rst_mem_addr", mem_addr, 0);
        reset = 1'b0;
        next();

        // Single fetch read.
        f_req = 1'b1; f_addr = 16'h0010; mem_rdata = 16'hBEEF;
        for (int c = 1; c <= 2; c++) begin
            next();
            cmp("f_mem_en", mem_en, 1);
            cmp("f_mem_addr", mem_addr, 16'h0010);
            cmp("f_mem_we", mem_we, 0);
        end
        next();
        cmp("f_done", f_done, 1);
        cmp("f_rdata", rdata, 16'hBEEF);
        cmp("f_d_done", d_done, 0);
        cmp("f_en_drop", mem_en, 0);
        f_req = 1'b0;
        next();
        cmp("f_done_once", f_done, 0);
        cmp("f_idle", busy, 0);

        // Data write, with address changed mid-access.
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1234; mem_rdata = 16'h5555;
        next();
        cmp("w_mem_we1", mem_we, 1);
        cmp("w_wdata1", mem_wdata, 16'h1234);
        cmp("w_addr1", mem_addr, 16'h0200);
        d_addr = 16'h0300;
        next();
        cmp("w_mem_we2", mem_we, 1);
        cmp("w_addr2", mem_addr, 16'h0200);
        next();
        cmp("w_d_done", d_done, 1);
        cmp("w_rdata_kept", rdata, 16'hBEEF);
        d_req = 1'b0; d_we = 1'b0;
        next();
        cmp("w_done_once", d_done, 0);

        // Both requests held from reset: data, fetch, data, fetch.
        #2 reset = 1'b1; f_req = 1'b1; d_req = 1'b1; f_addr = 16'h0100; d_addr = 16'h0500;
        next();
        #2 reset = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            next();
            cmp("rr_busy", busy, (c % 4) != 0);
            cmp("rr_d_done", d_done, (c % 4 == 3) && ((c / 4) % 2 == 0));
            cmp("rr_f_done", f_done, (c % 4 == 3) && ((c / 4) % 2 == 1));
            if (c % 4 != 0) cmp("rr_owner", owner, (c / 4) % 2 == 0);
            if (c == 15) begin f_req = 1'b0; d_req = 1'b0; end
        end

        // Reset in the second access cycle abandons the access.
        f_req = 1'b1; f_addr = 16'h0040; mem_rdata = 16'h7777;
        next();
        cmp("ra_en1", mem_en, 1);
        next();
        #2 reset = 1'b1; f_req = 1'b0;
        #1;
        cmp("ra_en_now", mem_en, 0);
        cmp("ra_busy_now", busy, 0);
        cmp("ra_rdata_now", rdata, 0);
        next();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            next();
            cmp("ra_no_fdone", f_done, 0);
            cmp("ra_no_ddone", d_done, 0);
        end
        f_req = 1'b1; f_addr = 16'h0044; mem_rdata = 16'h9999;
        next(); cmp("ra2_en1", mem_en, 1);
        next(); cmp("ra2_en2", mem_en, 1);
        next(); cmp("ra2_done", f_done, 1); cmp("ra2_rdata", rdata, 16'h9999);
        f_req = 1'b0;
        next();

        // Zero wait states.
        f_req0 = 1'b1; f_addr0 = 16'h0080; mem_rdata0 = 16'hA5A5;
        next();
        cmp("ws0_en1", mem_en0, 1);
        cmp("ws0_addr", mem_addr0, 16'h0080);
        cmp("ws0_nodone1", f_done0, 0);
        next();
        cmp("ws0_en2", mem_en0, 0);
        cmp("ws0_done", f_done0, 1);
        cmp("ws0_rdata", rdata0, 16'hA5A5);
        f_req0 = 1'b0;
        next();
        cmp("ws0_done_once", f_done0, 0);
        cmp("ws0_idle", busy0, 0);

        // Randomized traffic with occasional asynchronous reset.
        for (int i = 0; i < 3000; i++) begin
            next();
            if (reset) reset = 1'b0;
            mem_rdata = 16'($urandom);
            if (f_req && f_done) f_req = 1'b0;
            else if (!f_req && $urandom_range(0, 2) == 0) begin
                f_req = 1'b1; f_addr = 16'($urandom);
            end else if ($urandom_range(0, 7) == 0) f_addr = 16'($urandom);
            if (d_req && d_done) d_req = 1'b0;
            else if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1'b1; d_we = 1'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
            end else if ($urandom_range(0, 7) == 0) begin
                d_we = 1'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
            end
            if ($urandom_range(0, 399) == 0) begin
                #2 reset = 1'b1; f_req = 1'b0; d_req = 1'b0;
            end
        end
        next();
        reset = 1'b0;
        repeat (2) next();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the CPU's single synchronous memory port between the instruction-fetch path (driven during the control FSM's fetch state) and the data path (LOAD/STORE and IN/OUT states).
- Arbitrates simultaneous requests and inserts a configurable number of memory wait states.
- Returns a one-cycle done pulse to the winning requester, so the control FSM can stall until memory completes.

Parameters:
- ADDR_WIDTH, 16, memory address width.
- DATA_WIDTH, 16, memory data width.
- WAIT_STATES, 1, extra cycles mem_en is held beyond the first; legal range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- f_req  in  1  fetch request, level; held until f_done.
- f_addr  in  ADDR_WIDTH  fetch address.
- d_req  in  1  data request, level; held until d_done.
- d_we  in  1  data request is a write (1) or read (0).
- d_addr  in  ADDR_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  data write value.
- f_done  out  1  one-cycle pulse: fetch complete, rdata valid.
- d_done  out  1  one-cycle pulse: data access complete; rdata valid if read.
- rdata  out  DATA_WIDTH  read data, registered; holds until next read completes.
- busy  out  1  high in ACCESS and DONE.
- owner  out  1  current/last grant: 0 = fetch, 1 = data.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable (only with mem_en).
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data; valid in the last ACCESS cycle.

Behaviour:
- Reset (asynchronous, immediate, any state):
  - state=IDLE.
  - All outputs 0, rdata=0.
  - owner=0 (last grant = fetch), wait counter=0.
  - Any in-flight access is abandoned with no done pulse.
- All outputs are registered.
- FSM states are IDLE, ACCESS and DONE.
- IDLE:
  - On a clock edge with no request, stay in IDLE.
  - On a clock edge with one request, grant that requester.
  - On a clock edge with both requests, grant the requester not served last: if owner==0, grant data; otherwise grant fetch. This gives alternating fairness; after reset, data wins first.
  - On a grant:
    - Capture the granted address; capture we/wdata for data, forcing we=0 for fetch.
    - Set owner, load counter=WAIT_STATES, go to ACCESS.
- ACCESS:
  - mem_en=1 and mem_addr/mem_we/mem_wdata drive the captured values, stable for all WAIT_STATES+1 cycles.
  - Each edge with counter!=0 decrements the counter.
  - On the edge with counter==0:
    - If the access is a read, register mem_rdata into rdata; a write leaves rdata unchanged.
    - Go to DONE.
    - mem_en and mem_we drop to 0 in the following cycle.
- DONE:
  - Pulse f_done or d_done (per owner) for exactly 1 cycle, then go to IDLE.
  - Requests are not sampled in DONE.
  - The requester must deassert req in the cycle after done. A req still high when IDLE samples is a new request.
- Inputs are captured only at grant. Changes to addr/we/wdata during ACCESS are ignored.
- A request dropped mid-access does not abort it: the access completes and done still pulses.
- Latency: with req high in cycle 0 while IDLE, mem_en is high in cycles 1..WAIT_STATES+1 and done is high in cycle WAIT_STATES+2.
- Back-to-back accesses take a minimum of WAIT_STATES+3 cycles each, because one IDLE cycle is required between them.
- WAIT_STATES=0: ACCESS lasts exactly 1 cycle.
- Counter width is 4 bits.
- busy=1 in ACCESS and DONE, 0 in IDLE.

Test Plan:
- Reset with WAIT_STATES=1, then f_req=1 and f_addr=0x0010 in cycle 0 with mem returning 0xBEEF → mem_en=1 with mem_addr=0x0010 and mem_we=0 in cycles 1–2; f_done=1 and rdata=0xBEEF in cycle 3; d_done stays 0.
- Data write: d_req=1, d_we=1, d_addr=0x0200, d_wdata=0x1234 → mem_we=1 and mem_wdata=0x1234 for 2 cycles; d_done pulses once; rdata is unchanged from its prior value.
- f_req and d_req both held high from reset → grants in the order data, fetch, data, fetch (owner toggles); each done pulses exactly once per access; an IDLE cycle separates the accesses.
- Change d_addr from 0x0200 to 0x0300 during ACCESS → mem_addr stays 0x0200 throughout the access.
- Assert reset in the second ACCESS cycle → mem_en=0, busy=0 and rdata=0 immediately (before the next clock edge); no done pulse follows; the next f_req is served normally with the full WAIT_STATES+2 latency.
- Rebuild with WAIT_STATES=0 → mem_en is high for 1 cycle and done is high in cycle 2 after the request.
